// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: decode-side control, instruction memory bus
// and the IF/ID register outputs.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  imem_ready,
    input  imem_rdata,
    output imem_req,
    output imem_addr,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc_plus4
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_target,
    output imem_ready,
    output imem_rdata,
    input  imem_req,
    input  imem_addr,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc_plus4
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry
// skid buffer for stalled responses, and an IF/ID output register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_DISCARD,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] p4_q, p4_d;

  logic        redir;
  logic        stall;
  logic        ready;
  logic        take;
  logic        deliver;
  logic [31:0] word;
  logic [31:0] pc_plus4;

  assign redir    = bus.redirect_valid;
  assign stall    = bus.stall;
  assign ready    = bus.imem_ready;
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ISSUE: begin
        state_d = redir ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (ready) begin
          state_d = (stall && !redir) ? S_HOLD : S_ISSUE;
        end else if (redir) begin
          state_d = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (redir || !stall) begin
          state_d = S_ISSUE;
        end
      end
      S_DISCARD: begin
        if (ready) begin
          state_d = S_ISSUE;
        end
      end
    endcase
  end

  // Request is suppressed while reset is held so nothing leaves early.
  always_comb begin
    bus.imem_req  = (state_q == S_ISSUE) && !rst;
    bus.imem_addr = pc_q;
  end

  always_comb begin
    take    = (state_q == S_WAIT) && ready;
    deliver = !redir && !stall &&
              (take || (state_q == S_HOLD));
    word    = (state_q == S_HOLD) ? skid_q
                                  : bus.imem_rdata;

    pc_d = pc_q;
    if (redir) begin
      pc_d = bus.redirect_target & ~32'd3;
    end else if (deliver) begin
      pc_d = pc_plus4;
    end

    skid_d = skid_q;
    if (take && stall && !redir) begin
      skid_d = bus.imem_rdata;
    end

    valid_d = 1'b0;
    if (redir) begin
      valid_d = 1'b0;
    end else if (deliver) begin
      valid_d = 1'b1;
    end else if (stall) begin
      valid_d = valid_q;
    end

    instr_d = deliver ? word : instr_q;
    p4_d    = deliver ? pc_plus4 : p4_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      skid_q  <= 32'd0;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      p4_q    <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      p4_q    <= p4_d;
    end
  end

  assign bus.if_id_valid    = valid_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = p4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: directed cycle table for the corner cases, then
// random traffic against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic clk;
  logic rst;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] p4;
  } vec_t;

  vec_t tbl [26];

  int vecs;
  int errs;

  // reference model: request in flight, drop flag, buffered word
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_drop;
  logic        m_buf;
  logic [31:0] m_bw;
  logic        m_v;
  logic [31:0] m_instr;
  logic [31:0] m_p4;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic st, logic rd,
                       logic [31:0] tg, logic rdy,
                       logic [31:0] rdt);
    @(negedge clk);
    rst                 = r;
    bus.stall           = st;
    bus.redirect_valid  = rd;
    bus.redirect_target = tg;
    bus.imem_ready      = rdy;
    bus.imem_rdata      = rdt;
    #1;
  endtask

  task automatic model_update(logic r, logic st, logic rd,
                              logic [31:0] tg, logic rdy,
                              logic [31:0] rdt);
    logic        idle;
    logic        dlv;
    logic [31:0] w;
    idle = !m_busy && !m_buf;
    dlv  = 1'b0;
    w    = 32'd0;
    if (r) begin
      m_pc    = RPC;
      m_busy  = 1'b0;
      m_drop  = 1'b0;
      m_buf   = 1'b0;
      m_v     = 1'b0;
      m_instr = 32'd0;
      m_p4    = 32'd0;
    end else if (rd) begin
      m_pc  = tg & ~32'd3;
      m_v   = 1'b0;
      m_buf = 1'b0;
      if (idle) begin
        m_busy = 1'b1;
        m_drop = 1'b1;
      end else if (m_busy) begin
        if (rdy) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      if (idle) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
      end else if (m_busy && m_drop) begin
        if (rdy) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
      end else if (m_busy) begin
        if (rdy) begin
          m_busy = 1'b0;
          if (st) begin
            m_buf = 1'b1;
            m_bw  = rdt;
          end else begin
            dlv = 1'b1;
            w   = rdt;
          end
        end
      end else if (!st) begin
        m_buf = 1'b0;
        dlv   = 1'b1;
        w     = m_bw;
      end
      if (dlv) begin
        m_v     = 1'b1;
        m_instr = w;
        m_p4    = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
      end else if (!st) begin
        m_v = 1'b0;
      end
    end
  endtask

  initial begin
    logic        r, st, rd, rdy, ereq;
    logic [31:0] tg, rdt, pdata;
    bit          pend;
    int          due;

    vecs = 0;
    errs = 0;
    m_bw = 32'd0;
    pend = 1'b0;
    due  = 0;
    pdata = 32'd0;

    // rst st rd tgt rdy rdata | req addr v instr p4
    tbl[0]  = '{1,0,0,0,0,0, 0,0,0,0,0};
    tbl[1]  = '{0,0,0,0,0,0, 1,RPC,0,0,0};
    tbl[2]  = '{0,0,0,0,1,32'h2408_0005, 0,0,0,0,0};
    tbl[3]  = '{0,1,0,0,0,0,
                1,32'h0040_0004,1,32'h2408_0005,32'h0040_0004};
    tbl[4]  = '{0,1,0,0,1,32'h0000_0020,
                0,0,1,32'h2408_0005,32'h0040_0004};
    tbl[5]  = '{0,1,0,0,0,0,
                0,0,1,32'h2408_0005,32'h0040_0004};
    tbl[6]  = '{0,0,0,0,0,0,
                0,0,1,32'h2408_0005,32'h0040_0004};
    tbl[7]  = '{0,0,1,32'hFFFF_FFFF,0,0,
                1,32'h0040_0008,1,32'h0000_0020,32'h0040_0008};
    tbl[8]  = '{0,0,0,0,1,32'hDEAD_BEEF,
                0,0,0,32'h0000_0020,32'h0040_0008};
    tbl[9]  = '{0,0,0,0,0,0,
                1,32'hFFFF_FFFC,0,32'h0000_0020,32'h0040_0008};
    tbl[10] = '{0,0,0,0,1,32'h1234_5678,
                0,0,0,32'h0000_0020,32'h0040_0008};
    tbl[11] = '{0,0,0,0,0,0,
                1,32'h0000_0000,1,32'h1234_5678,32'h0};
    tbl[12] = '{0,0,1,32'h0040_0100,0,0,
                0,0,0,32'h1234_5678,32'h0};
    tbl[13] = '{0,0,0,0,0,0,
                0,0,0,32'h1234_5678,32'h0};
    tbl[14] = '{0,0,0,0,1,32'hBADB_AD00,
                0,0,0,32'h1234_5678,32'h0};
    tbl[15] = '{0,0,0,0,0,0,
                1,32'h0040_0100,0,32'h1234_5678,32'h0};
    tbl[16] = '{0,1,0,0,1,32'hAAAA_0001,
                0,0,0,32'h1234_5678,32'h0};
    tbl[17] = '{0,1,1,32'h0050_0000,0,0,
                0,0,0,32'h1234_5678,32'h0};
    tbl[18] = '{0,1,0,0,0,0,
                1,32'h0050_0000,0,32'h1234_5678,32'h0};
    tbl[19] = '{0,0,0,0,1,32'h1111_2222,
                0,0,0,32'h1234_5678,32'h0};
    tbl[20] = '{0,0,0,0,0,0,
                1,32'h0050_0004,1,32'h1111_2222,32'h0050_0004};
    tbl[21] = '{1,0,0,0,0,0,
                0,0,0,32'h1111_2222,32'h0050_0004};
    tbl[22] = '{0,0,0,0,1,32'hCAFE_F00D,
                1,RPC,0,0,0};
    tbl[23] = '{0,0,0,0,0,0, 0,0,0,0,0};
    tbl[24] = '{0,0,0,0,1,32'h0BAD_C0DE, 0,0,0,0,0};
    tbl[25] = '{0,0,0,0,0,0,
                1,32'h0040_0004,1,32'h0BAD_C0DE,32'h0040_0004};

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].redir,
            tbl[i].tgt, tbl[i].rdy, tbl[i].rdata);
      chk($sformatf("t%0d req", i),
          {31'd0, bus.imem_req}, {31'd0, tbl[i].req});
      if (tbl[i].req)
        chk($sformatf("t%0d addr", i),
            bus.imem_addr, tbl[i].addr);
      chk($sformatf("t%0d valid", i),
          {31'd0, bus.if_id_valid}, {31'd0, tbl[i].v});
      chk($sformatf("t%0d instr", i),
          bus.if_id_instr, tbl[i].instr);
      chk($sformatf("t%0d pc4", i),
          bus.if_id_pc_plus4, tbl[i].p4);
    end

    for (int c = 0; c < 3000; c++) begin
      r   = (c == 0) || ($urandom_range(0, 63) == 0);
      st  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      tg  = $urandom;
      if ($urandom_range(0, 7) == 0) tg = 32'hFFFF_FFFC;
      rdy = pend && (due == c);
      rdt = rdy ? pdata : $urandom;
      drive(r, st, rd, tg, rdy, rdt);
      if (c > 0) begin
        ereq = !r && !m_busy && !m_buf;
        chk($sformatf("r%0d req", c),
            {31'd0, bus.imem_req}, {31'd0, ereq});
        if (ereq)
          chk($sformatf("r%0d addr", c),
              bus.imem_addr, m_pc);
        chk($sformatf("r%0d valid", c),
            {31'd0, bus.if_id_valid}, {31'd0, m_v});
        chk($sformatf("r%0d instr", c),
            bus.if_id_instr, m_instr);
        chk($sformatf("r%0d pc4", c),
            bus.if_id_pc_plus4, m_p4);
      end else begin
        ereq = 1'b0;
      end
      if (rdy || r) pend = 1'b0;
      if (ereq) begin
        pend  = 1'b1;
        due   = c + $urandom_range(1, 3);
        pdata = $urandom;
      end
      model_update(r, st, rd, tg, rdy, rdt);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
